seq_pattern_detect: RTL and testbench
=====================================

# seq_pattern_detect

Parametrised serial pattern detector: next generation of the fixed 3-bit "101" detector. Samples a valid-qualified serial bit stream and pulses `match` whenever the most recent `cfg_len` accepted bits equal a run-time programmable pattern of up to `MAX_LEN` bits. Supports overlapping and non-overlapping detection modes. Sits between a serial deserialiser front end and control logic that counts or reacts to framing/sync words.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits; must be >= 1.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `cfg_len`; derived, not overridden.
- `RST_PATTERN`, `'b101`: pattern register value after reset; `MAX_LEN` bits wide.
- `RST_LEN`, 3: length register value after reset.
- `RST_OVERLAP`, 1: overlap-mode register value after reset.
- `CNT_W`, 16: match counter width; used only with `SEQ_DET_MATCH_CNT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low; clears all state.
- `en`  in  1  detector enable; 0 forces IDLE and clears history.
- `cfg_load`  in  1  single-cycle strobe; latches `cfg_pattern`, `cfg_len`, `cfg_overlap`.
- `cfg_pattern`  in  `MAX_LEN`  pattern; bit `cfg_len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  `LEN_W`  pattern length; 0 is stored as 1, values > `MAX_LEN` are stored as `MAX_LEN`.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = history cleared after each match.
- `s_valid`  in  1  `s_data` qualifier.
- `s_data`  in  1  serial data bit.
- `match`  out  1  registered one-cycle pulse per detected pattern.
- `state`  out  2  current FSM state, for debug.
- `match_cnt`  out  `CNT_W`  saturating match count; present only with `SEQ_DET_MATCH_CNT_EN`.

## Operation
- A bit is accepted when `en`=1, `cfg_load`=0, and `s_valid`=1.
- Accepted bit shifts into the `MAX_LEN` window at the LSB. `fill` counts accepted bits since the last clear and saturates at `len-1`.
- Compare on an accepted bit when `fill == len-1`: `{window[len-2:0], s_data} == pattern[len-1:0]`. Bits above `len` are masked.
- FSM states:
  - IDLE (reset, or `en`=0): window=0, fill=0; goes to FILL when `en`=1.
  - FILL (`fill < len-1`): each accepted bit increments `fill`. On the accepted bit at `fill == len-1`, compare and go to HUNT.
  - HUNT: compare on every accepted bit.
    - On a match with overlap=1, stay in HUNT.
    - On a match with overlap=0, clear window and fill, go to FILL.
    - With `len`=1 and overlap=0, every accepted bit is still compared.
- `en`=0 in any state → IDLE on the next edge, history cleared. Pattern, length, and overlap registers are kept.
- `cfg_load` has priority over `s_valid`:
  - the bit in that cycle is dropped;
  - window and fill are cleared;
  - the next state is FILL if `en`=1, else IDLE;
  - the new config is used from the next cycle.
- Reset values:
  - `match`=0, `state`=IDLE, `match_cnt`=0;
  - pattern/len/overlap = `RST_PATTERN`/`RST_LEN`/`RST_OVERLAP`.

## Timing
- Latency: `match` is high for exactly the one cycle after the edge that accepted the completing bit.
- Idle cycles (`s_valid`=0) never produce `match` and do not disturb history.
- Back-to-back matches on consecutive accepted bits are possible with overlap=1 and a self-overlapping pattern (e.g. `len`=1).
- `rst` low clears everything immediately, including a `match` in flight. Operation resumes on the first edge after deassertion.

## Configuration
- `SEQ_DET_MATCH_CNT_EN` defined:
  - the `match_cnt` port and register exist;
  - increments with every `match` pulse and saturates at all-ones;
  - cleared by reset and `cfg_load`.
- Not defined: the port and counter are absent; detection behaviour is identical.

## Structure
- `seq_det_pkg` holds the state enum `seq_det_state_e` {IDLE, FILL, HUNT}, 2-bit encoding 0/1/2, and the length clamp function.
- One sub-module: `seq_det_window`. It holds the shift window, the fill counter, and the masked comparator, and outputs `hit` combinationally for the current accepted bit.

## Test plan
- Reset defaults, `en`=1, stream 1,0,1,0,1 on consecutive cycles → `match` one cycle after bit 3 and after bit 5.
- Load pattern `'b101`, `len`=3, overlap=0; stream 1,0,1,0,1,1,0,1 → `match` after bits 3 and 8 only.
- Same stream as the first scenario with 2 idle cycles between each bit → same two matches, each a single cycle following the accepting edge.
- Load `len`=8, pattern `8'hA5`, stream A5 MSB-first → one match after bit 8. Load `len`=1, pattern 1, stream 1,1,0,1 → matches after bits 1, 2, 4.
- Stream 1,0, then `cfg_load` with `s_valid`=1, `s_data`=1 in the same cycle, then 0,1 → no match; a further 1,0,1 → match after the last bit.
- Assert `rst` low mid-window after 1,0 → outputs cleared immediately; after release, 1 alone gives no match. With the macro, `CNT_W`=2 and 5 matches → `match_cnt` saturates at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } seq_det_state_e;

    // Programmed length 0 means a single-bit pattern; anything beyond the window is cut to the window.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// Shift window, fill counter and masked comparator for the pattern detector.
// Latency: cmp/hit are combinational on the bit being accepted this cycle.
// Backpressure: none; clr overrides a shift in the same cycle.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               cmp,
    output logic               hit
);

    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   len_m1;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;

    assign len_m1 = len - LEN_W'(1);

    // Only MAX_LEN-1 bits of history are needed: the newest bit comes straight from din.
    if (MAX_LEN > 1) begin : g_hist
        localparam int unsigned HIST_W = MAX_LEN - 1;
        logic [HIST_W-1:0] hist_q;

        assign cand = {hist_q, din};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hist_q <= '0;
            end else if (clr) begin
                hist_q <= '0;
            end else if (acc) begin
                hist_q <= cand[HIST_W-1:0];
            end
        end
    end else begin : g_no_hist
        assign cand = din;
    end

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    assign cmp = acc && (fill_q == len_m1);
    assign hit = cmp && (((cand ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= '0;
        end else if (clr) begin
            fill_q <= '0;
        end else if (acc && (fill_q < len_m1)) begin
            fill_q <= fill_q + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detect.sv
// Programmable serial pattern detector; SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
// Latency: match pulses one cycle after the edge that accepts the completing bit.
// Backpressure: none; s_valid only qualifies data, cfg_load drops the coincident bit.
module seq_pattern_detect
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = 'b101,
    parameter int unsigned          RST_LEN     = 3,
    parameter logic                 RST_OVERLAP = 1'b1,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               s_valid,
    input  logic               s_data,
    output logic               match,
    output logic [1:0]         state
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    if (MAX_LEN < 1 || CNT_W < 1) begin : g_bad_params
        $error("seq_pattern_detect: MAX_LEN and CNT_W must be at least 1");
    end

    seq_det_state_e     state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               acc;
    logic               clr;
    logic               cmp;
    logic               hit;

    assign acc   = en && !cfg_load && s_valid;
    // History is dropped when disabled, on reconfiguration, and after a non-overlapping match.
    assign clr   = !en || cfg_load || (hit && !ovl_q);
    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= RST_PATTERN;
            len_q <= LEN_W'(clamp_len(RST_LEN, MAX_LEN));
            ovl_q <= RST_OVERLAP;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_q <= cfg_overlap;
        end
    end

    seq_det_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .acc     (acc),
        .din     (s_data),
        .pattern (pat_q),
        .len     (len_q),
        .cmp     (cmp),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (!en) begin
                state_q <= IDLE;
            end else if (cfg_load) begin
                state_q <= FILL;
            end else if (cmp) begin
                state_q <= (hit && !ovl_q) ? FILL : HUNT;
            end else if (state_q == IDLE) begin
                state_q <= FILL;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (cfg_load) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed bench for seq_pattern_detect: each scenario task drives bits and compares against hand-derived results.
module tb_seq_pattern_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_data = 1'b0;
    logic       match;
    logic [1:0] state;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [1:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detect #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .match       (match),
        .state       (state)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    task automatic step(input logic v, input logic d, output logic m);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
        m       = match;
        s_valid = 1'b0;
        s_data  = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL reset_match got %b want 0", match);
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", match_cnt);
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_default_overlap();
        logic [4:0] bits = 5'b10101;
        logic [4:0] expv = 5'b00101;
        logic m;
        en = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL default_overlap bit%0d got %b want %b", 5 - i, m, expv[i]);
            end
            if (i == 4) begin
                checks++;
                if (state !== 2'd1) begin
                    errors++;
                    $display("FAIL default_state_fill got %0d want 1", state);
                end
            end
        end
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL default_state_hunt got %0d want 2", state);
        end
    endtask

    task automatic test_non_overlap();
        logic [7:0] bits = 8'b10101101;
        logic [7:0] expv = 8'b00100001;
        logic m;
        load(8'b101, 4'd3, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL non_overlap bit%0d got %b want %b", 8 - i, m, expv[i]);
            end
            if (i == 5) begin
                checks++;
                if (state !== 2'd1) begin
                    errors++;
                    $display("FAIL non_overlap_state got %0d want 1", state);
                end
            end
        end
    endtask

    task automatic test_idle_gaps();
        logic [4:0] bits = 5'b10101;
        logic [4:0] expv = 5'b00101;
        logic m;
        load(8'b101, 4'd3, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL idle_gaps bit%0d got %b want %b", 5 - i, m, expv[i]);
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'b1, m);
                checks++;
                if (m !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gaps_idle bit%0d gap%0d got %b want 0", 5 - i, g, m);
                end
            end
        end
    endtask

    task automatic test_long_len();
        logic [7:0] bits = 8'hA5;
        logic [7:0] expv = 8'h01;
        logic m;
        load(8'hA5, 4'd8, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL len8 bit%0d got %b want %b", 8 - i, m, expv[i]);
            end
        end
        load(8'hA5, 4'd15, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL len_clamp_max bit%0d got %b want %b", 8 - i, m, expv[i]);
            end
        end
    endtask

    task automatic test_short_len();
        logic [3:0] bits1 = 4'b1101;
        logic [3:0] exp1  = 4'b1101;
        logic [2:0] bits0 = 3'b010;
        logic [2:0] exp0  = 3'b101;
        logic m;
        load(8'h01, 4'd1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits1[i], m);
            checks++;
            if (m !== exp1[i]) begin
                errors++;
                $display("FAIL len1_no_overlap bit%0d got %b want %b", 4 - i, m, exp1[i]);
            end
        end
        load(8'h00, 4'd0, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, bits0[i], m);
            checks++;
            if (m !== exp0[i]) begin
                errors++;
                $display("FAIL len0_clamp bit%0d got %b want %b", 3 - i, m, exp0[i]);
            end
        end
    endtask

    task automatic test_cfg_priority();
        logic [4:0] bits = 5'b01101;
        logic [4:0] expv = 5'b00001;
        logic m;
        load(8'b101, 4'd3, 1'b1);
        step(1'b1, 1'b1, m);
        step(1'b1, 1'b0, m);
        cfg_load    = 1'b1;
        cfg_pattern = 8'b101;
        cfg_len     = 4'd3;
        cfg_overlap = 1'b1;
        s_valid     = 1'b1;
        s_data      = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        s_valid  = 1'b0;
        s_data   = 1'b0;
        checks++;
        if (match !== 1'b0 || state !== 2'd1) begin
            errors++;
            $display("FAIL cfg_priority_cycle got match=%b state=%0d want match=0 state=1", match, state);
        end
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL cfg_priority bit%0d got %b want %b", 5 - i, m, expv[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic [2:0] bits = 3'b101;
        logic [2:0] expv = 3'b001;
        logic m;
        load(8'b101, 4'd3, 1'b1);
        step(1'b1, 1'b1, m);
        step(1'b1, 1'b0, m);
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL enable_idle_state got %0d want 0", state);
        end
        en = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL enable_history bit%0d got %b want %b", 3 - i, m, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] bits = 3'b101;
        logic [2:0] expv = 3'b001;
        logic m;
        load(8'b10, 4'd2, 1'b1);
        step(1'b1, 1'b1, m);
        step(1'b1, 1'b0, m);
        checks++;
        if (m !== 1'b1) begin
            errors++;
            $display("FAIL len2_match got %b want 1", m);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (match !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got match=%b state=%0d want match=0 state=0", match, state);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL reset_restores_cfg bit%0d got %b want %b", 3 - i, m, expv[i]);
            end
        end
        step(1'b1, 1'b1, m);
        step(1'b1, 1'b0, m);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, bits[i], m);
            checks++;
            if (m !== expv[i]) begin
                errors++;
                $display("FAIL reset_mid_window bit%0d got %b want %b", 3 - i, m, expv[i]);
            end
        end
    endtask

`ifdef SEQ_DET_MATCH_CNT_EN
    task automatic test_counter();
        logic m;
        load(8'h01, 4'd1, 1'b1);
        checks++;
        if (match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_load_clear got %0d want 0", match_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, m);
            checks++;
            if (m !== 1'b1) begin
                errors++;
                $display("FAIL cnt_back_to_back bit%0d got %b want 1", i, m);
            end
            if (i == 3) begin
                checks++;
                if (match_cnt !== 2'd2) begin
                    errors++;
                    $display("FAIL cnt_mid got %0d want 2", match_cnt);
                end
            end
        end
        step(1'b0, 1'b0, m);
        step(1'b0, 1'b0, m);
        checks++;
        if (match_cnt !== 2'd3) begin
            errors++;
            $display("FAIL cnt_saturate got %0d want 3", match_cnt);
        end
        load(8'h01, 4'd1, 1'b1);
        checks++;
        if (match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_reload_clear got %0d want 0", match_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_overlap();
        test_non_overlap();
        test_idle_gaps();
        test_long_len();
        test_short_len();
        test_cfg_priority();
        test_enable();
        test_reset_mid();
`ifdef SEQ_DET_MATCH_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
